// File: rtl/ten_bit_counter_pkg.sv
// rtl/ten_bit_counter_pkg.sv - shared types, defaults and helpers for ten_bit_counter
// Contents:
//   state_e          : run-control FSM states (IDLE, RUN, DONE)
//   DEF_WIDTH        : default counter width
//   DEF_MAX_VAL      : default up-count terminal value
//   DEF_PRESCALE     : default enabled RUN cycles per count step
//   clamp_load()     : limits a load value to the terminal value
package ten_bit_counter_pkg;

  localparam int DEF_WIDTH    = 10;
  localparam int DEF_MAX_VAL  = 1023;
  localparam int DEF_PRESCALE = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // A loaded value above the terminal value would leave the counter in a
  // state it can never reach by counting, so it is pinned to max_val.
  function automatic logic [31:0] clamp_load(input logic [31:0] val,
                                             input logic [31:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/ten_bit_counter_if.sv
// rtl/ten_bit_counter_if.sv - control/status bundle between a controller and ten_bit_counter
// Signals:
//   en, up, oneshot   : run enable, direction (1 up), stop-at-terminal mode
//   clr, load         : synchronous clear / load strobes (clr has priority)
//   load_val [WIDTH]  : value written on load
//   count [WIDTH]     : registered count
//   tc                : registered terminal-count pulse
//   busy              : high while the counter is in RUN
//   cnt_stb           : registered one-cycle pulse when count changed
// Modports: master drives controls and observes status; slave is the counter.
interface ten_bit_counter_if
  import ten_bit_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             en;
  logic             up;
  logic             oneshot;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             busy;
  logic             cnt_stb;

  modport master (
    output en, up, oneshot, clr, load, load_val,
    input  count, tc, busy, cnt_stb
  );

  modport slave (
    input  en, up, oneshot, clr, load, load_val,
    output count, tc, busy, cnt_stb
  );

endinterface

// File: rtl/ten_bit_counter_tick_prescaler.sv
// rtl/ten_bit_counter_tick_prescaler.sv - divides RUN cycles down to count ticks
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   run      : counter is in RUN with enable high; prescaler advances
//   sync_clr : return the prescaler phase to 0 on the next edge
//   tick     : combinational, high in the RUN cycle that completes a period
module tick_prescaler
  import ten_bit_counter_pkg::*;
#(
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic sync_clr,
  output logic tick
);

  // A one-bit phase register is kept even for PRESCALE=1; it simply stays 0.
  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] psc_q;
  logic [PW-1:0] psc_d;

  assign tick = run && (psc_q == LAST);

  always_comb begin
    psc_d = psc_q;
    if (sync_clr) begin
      psc_d = '0;
    end else if (run) begin
      psc_d = tick ? '0 : psc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end

endmodule

// File: rtl/ten_bit_counter.sv
// rtl/ten_bit_counter.sv - up/down counter with prescaler, load/clear and oneshot mode
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-low reset
//   bus : ten_bit_counter_if.slave (en, up, oneshot, clr, load, load_val in;
//         count, tc, busy, cnt_stb out, all registered)
// Build option:
//   TEN_BIT_COUNTER_SATURATE_EN - a continuous-mode terminal tick holds the
//   count (tc only, no cnt_stb) instead of wrapping; oneshot is unaffected.
module ten_bit_counter
  import ten_bit_counter_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int MAX_VAL  = DEF_MAX_VAL,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic                clk,
  input  logic                rst,
  ten_bit_counter_if.slave    bus
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;
  logic             cnt_stb_q;
  logic             cnt_stb_d;

  logic             run;
  logic             tick;
  logic             psc_clr;
  logic             at_term;

  // Ticks are only produced while enabled in RUN; dropping en in RUN both
  // leaves RUN and discards the partial prescaler phase.
  assign run     = (state_q == RUN) && bus.en;
  assign psc_clr = bus.clr || bus.load || ((state_q == RUN) && !bus.en);
  assign at_term = bus.up ? (count_q == MAX_W) : (count_q == '0);

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .sync_clr (psc_clr),
    .tick     (tick)
  );

  // Datapath: clr > load > tick.
  always_comb begin
    count_d   = count_q;
    tc_d      = 1'b0;
    cnt_stb_d = 1'b0;
    if (bus.clr) begin
      count_d   = '0;
      cnt_stb_d = 1'b1;
    end else if (bus.load) begin
      count_d   = WIDTH'(clamp_load(32'(bus.load_val), 32'(MAX_VAL)));
      cnt_stb_d = 1'b1;
    end else if (tick) begin
      if (at_term) begin
        tc_d = 1'b1;
        if (!bus.oneshot) begin
`ifdef TEN_BIT_COUNTER_SATURATE_EN
          count_d = count_q;
`else
          count_d   = bus.up ? '0 : MAX_W;
          cnt_stb_d = 1'b1;
`endif
        end
      end else begin
        count_d   = bus.up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
        cnt_stb_d = 1'b1;
      end
    end
  end

  // Run-control FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.en && !bus.clr && !bus.load) state_d = RUN;
      end
      RUN: begin
        if (!bus.en) begin
          state_d = IDLE;
        end else if (tick && at_term && bus.oneshot && !bus.clr && !bus.load) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // DONE parks with en held high; only clr, load or en=0 re-arm it.
        if (bus.clr || bus.load || !bus.en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      tc_q      <= 1'b0;
      cnt_stb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      tc_q      <= tc_d;
      cnt_stb_q <= cnt_stb_d;
    end
  end

  assign bus.count   = count_q;
  assign bus.tc      = tc_q;
  assign bus.cnt_stb = cnt_stb_q;
  assign bus.busy    = (state_q == RUN);

endmodule

// File: tb/tb_ten_bit_counter.sv
// tb/tb_ten_bit_counter.sv - scoreboard bench for ten_bit_counter
// Instances:
//   u_p1 : WIDTH=11, MAX_VAL=1023, PRESCALE=1 (wrap, clamp of out-of-range load)
//   u_p4 : WIDTH=10, MAX_VAL=1023, PRESCALE=4 (oneshot, en drop, async reset)
module tb_ten_bit_counter;

  typedef struct {
    int cyc;
    int count;
    int tc;
    int stb;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_errors;
  ev_t  q1[$];
  ev_t  q4[$];
  ev_t  e1;
  ev_t  e4;

  ten_bit_counter_if #(.WIDTH(11)) bus1 ();
  ten_bit_counter_if #(.WIDTH(10)) bus4 ();

  ten_bit_counter #(.WIDTH(11), .MAX_VAL(1023), .PRESCALE(1)) u_p1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  ten_bit_counter #(.WIDTH(10), .MAX_VAL(1023), .PRESCALE(4)) u_p4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push1(input int c, input int cnt, input int tc, input int stb);
    ev_t e;
    e.cyc = c; e.count = cnt; e.tc = tc; e.stb = stb;
    q1.push_back(e);
  endtask

  task automatic push4(input int c, input int cnt, input int tc, input int stb);
    ev_t e;
    e.cyc = c; e.count = cnt; e.tc = tc; e.stb = stb;
    q4.push_back(e);
  endtask

  // Monitors: every tc or cnt_stb cycle must match the next expected event,
  // including the cycle on which it appears.
  always @(negedge clk) begin
    if (rst && (bus1.tc || bus1.cnt_stb)) begin
      if (q1.size() == 0) begin
        chk("p1_unexpected_event_count", int'(bus1.count), -1);
      end else begin
        e1 = q1.pop_front();
        chk("p1_event_cycle", cyc, e1.cyc);
        chk("p1_event_count", int'(bus1.count), e1.count);
        chk("p1_event_tc", int'(bus1.tc), e1.tc);
        chk("p1_event_stb", int'(bus1.cnt_stb), e1.stb);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && (bus4.tc || bus4.cnt_stb)) begin
      if (q4.size() == 0) begin
        chk("p4_unexpected_event_count", int'(bus4.count), -1);
      end else begin
        e4 = q4.pop_front();
        chk("p4_event_cycle", cyc, e4.cyc);
        chk("p4_event_count", int'(bus4.count), e4.count);
        chk("p4_event_tc", int'(bus4.tc), e4.tc);
        chk("p4_event_stb", int'(bus4.cnt_stb), e4.stb);
      end
    end
  end

  initial begin
    int c;
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    bus1.en = 0; bus1.up = 0; bus1.oneshot = 0; bus1.clr = 0; bus1.load = 0; bus1.load_val = '0;
    bus4.en = 0; bus4.up = 0; bus4.oneshot = 0; bus4.clr = 0; bus4.load = 0; bus4.load_val = '0;

    #2;
    chk("rst_p1_count", int'(bus1.count), 0);
    chk("rst_p1_tc", int'(bus1.tc), 0);
    chk("rst_p1_busy", int'(bus1.busy), 0);
    chk("rst_p1_stb", int'(bus1.cnt_stb), 0);
    chk("rst_p4_count", int'(bus4.count), 0);
    chk("rst_p4_tc", int'(bus4.tc), 0);
    chk("rst_p4_busy", int'(bus4.busy), 0);
    chk("rst_p4_stb", int'(bus4.cnt_stb), 0);
    @(negedge clk);
    rst = 1'b1;

    // PRESCALE=1 continuous up across the terminal value.
    @(negedge clk);
    c = cyc;
    bus1.up = 1; bus1.oneshot = 0; bus1.load = 1; bus1.load_val = 11'd1021;
    push1(c + 1, 1021, 0, 1);
    @(negedge clk);
    c = cyc;
    bus1.load = 0; bus1.en = 1;
    chk("p1_busy_before_run", int'(bus1.busy), 0);
    push1(c + 2, 1022, 0, 1);
    push1(c + 3, 1023, 0, 1);
`ifdef TEN_BIT_COUNTER_SATURATE_EN
    push1(c + 4, 1023, 1, 0);
    push1(c + 5, 1023, 1, 0);
`else
    push1(c + 4, 0, 1, 1);
    push1(c + 5, 1, 0, 1);
`endif
    @(negedge clk);
    chk("p1_busy_one_cycle_after_en", int'(bus1.busy), 1);
    repeat (4) @(negedge clk);
    bus1.en = 0;
    @(negedge clk);
    chk("p1_busy_after_en_drop", int'(bus1.busy), 0);

    // clr beats load, then an out-of-range and an in-range load.
    @(negedge clk);
    c = cyc;
    bus1.clr = 1; bus1.load = 1; bus1.load_val = 11'd500;
    push1(c + 1, 0, 0, 1);
    @(negedge clk);
    c = cyc;
    bus1.clr = 0; bus1.load_val = 11'd1500;
    push1(c + 1, 1023, 0, 1);
    @(negedge clk);
    c = cyc;
    bus1.load_val = 11'd700;
    push1(c + 1, 700, 0, 1);
    @(negedge clk);
    bus1.load = 0;

    // PRESCALE=4 oneshot down from 2.
    @(negedge clk);
    c = cyc;
    bus4.up = 0; bus4.oneshot = 1; bus4.load = 1; bus4.load_val = 10'd2;
    push4(c + 1, 2, 0, 1);
    @(negedge clk);
    c = cyc;
    bus4.load = 0; bus4.en = 1;
    push4(c + 5, 1, 0, 1);
    push4(c + 9, 0, 0, 1);
    push4(c + 13, 0, 1, 0);
    repeat (13) @(negedge clk);
    chk("p4_oneshot_busy_low", int'(bus4.busy), 0);
    chk("p4_oneshot_count_held", int'(bus4.count), 0);
    repeat (8) @(negedge clk);
    chk("p4_done_no_restart_busy", int'(bus4.busy), 0);
    chk("p4_done_no_restart_count", int'(bus4.count), 0);
    c = cyc;
    bus4.clr = 1; bus4.en = 0;
    push4(c + 1, 0, 0, 1);
    @(negedge clk);
    bus4.clr = 0;

    // en dropped with the prescaler at 2, then re-entered.
    @(negedge clk);
    c = cyc;
    bus4.up = 1; bus4.oneshot = 0; bus4.load = 1; bus4.load_val = 10'd100;
    push4(c + 1, 100, 0, 1);
    @(negedge clk);
    bus4.load = 0; bus4.en = 1;
    repeat (3) @(negedge clk);
    bus4.en = 0;
    repeat (3) @(negedge clk);
    chk("p4_idle_count_hold", int'(bus4.count), 100);
    chk("p4_idle_busy", int'(bus4.busy), 0);
    c = cyc;
    bus4.en = 1;
    push4(c + 5, 101, 0, 1);
    repeat (5) @(negedge clk);
    bus4.en = 0;

    // Asynchronous reset while counting at 37.
    @(negedge clk);
    c = cyc;
    bus4.load = 1; bus4.load_val = 10'd35;
    push4(c + 1, 35, 0, 1);
    @(negedge clk);
    c = cyc;
    bus4.load = 0; bus4.en = 1;
    push4(c + 5, 36, 0, 1);
    push4(c + 9, 37, 0, 1);
    repeat (9) @(negedge clk);
    chk("p4_pre_reset_count", int'(bus4.count), 37);
    chk("p4_pre_reset_busy", int'(bus4.busy), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("p4_async_rst_count", int'(bus4.count), 0);
    chk("p4_async_rst_tc", int'(bus4.tc), 0);
    chk("p4_async_rst_busy", int'(bus4.busy), 0);
    chk("p4_async_rst_stb", int'(bus4.cnt_stb), 0);
    bus4.en = 0;
    @(negedge clk);
    rst = 1'b1;

    repeat (4) @(negedge clk);
    chk("p1_events_outstanding", q1.size(), 0);
    chk("p4_events_outstanding", q4.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ten_bit_counter.md
Name: ten_bit_counter

Overview:
- 10-bit up/down counter with prescaler, synchronous load/clear and continuous or one-shot run modes.
- Directly upstream of the 10-bit capture register stage; drives its data inputs.
- cnt_stb marks cycles where count changed, giving the downstream stage a capture qualifier.

Parameters:
- WIDTH, 10, counter width in bits.
- MAX_VAL, 1023, up-count terminal value; legal range 1..2^WIDTH-1.
- PRESCALE, 1, enabled RUN cycles per count step; legal range 1..1024.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- en  input  1  run enable.
- up  input  1  direction: 1 up, 0 down; sampled on each tick.
- oneshot  input  1  1 stop at terminal, 0 continuous; sampled on each tick.
- clr  input  1  synchronous clear.
- load  input  1  synchronous load.
- load_val  input  WIDTH  load value.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered.
- busy  output  1  high in RUN.
- cnt_stb  output  1  one-cycle pulse on count update, registered.

Behaviour:
- Reset (rst=0, async): count=0, tc=0, busy=0, cnt_stb=0, state=IDLE, prescaler=0. First update on the first clk edge after rst deasserts.
- Priority each edge: clr > load > tick.
- clr: count<=0, cnt_stb<=1, prescaler<=0; DONE->IDLE.
- load: count<=min(load_val, MAX_VAL), cnt_stb<=1, prescaler<=0; DONE->IDLE.
- FSM states: IDLE, RUN, DONE.
  - IDLE->RUN when en=1 and no clr/load.
  - RUN->IDLE when en=0; prescaler cleared.
  - RUN->DONE on a oneshot terminal tick.
  - DONE->IDLE on clr, load, or en=0. DONE holds count; busy=0.
- busy=1 iff state==RUN. It is registered with the state, so it rises 1 cycle after en.
- Prescaler:
  - Increments only in RUN.
  - tick when prescaler==PRESCALE-1; the prescaler then returns to 0.
  - With PRESCALE=1, tick occurs on every RUN cycle.
  - First tick lands PRESCALE cycles after entering RUN.
- Tick, non-terminal: count±1; cnt_stb=1 next cycle.
- Terminal tick: up with count==MAX_VAL, or down with count==0.
  - Continuous: count wraps (MAX_VAL->0 or 0->MAX_VAL); tc=1 and cnt_stb=1 for one cycle with the new count.
  - Oneshot: count holds; tc=1, cnt_stb=0; state->DONE.
- Direction change mid-run takes effect on the next tick. The prescaler phase is kept.
- tc and cnt_stb are 0 in every cycle not described above.
- Count above MAX_VAL cannot arise.
- Reset asserted mid-run aborts immediately to reset values.

Optional Feature:
- Macro: TEN_BIT_COUNTER_SATURATE_EN.
- Defined: in continuous mode a terminal tick holds count (no wrap); tc=1 on every terminal tick, cnt_stb=0, state stays RUN.
- Undefined: continuous wrap as above.
- Oneshot behaviour is identical either way.

Decomposition:
- Package ten_bit_counter_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - default WIDTH/MAX_VAL/PRESCALE constants;
  - a clamp function for load values.
- Sub-module tick_prescaler (parameter PRESCALE; inputs clk, rst, run, sync_clr; output tick).

Test Plan:
- rst pulse low mid-count (count=37): count=0, tc=0, busy=0, cnt_stb=0 asynchronously, with no clk edge needed.
- PRESCALE=1, up=1, oneshot=0, load 1021 then en=1: count 1022, 1023, 0, 1; tc high only with count=0; cnt_stb every tick.
- PRESCALE=4, down, load 2, en=1, oneshot=1: count=1 after 4 cycles, 0 after 8. At cycle 12, tc pulses, count stays 0, busy=0, state DONE. Subsequent en=1 does not restart until load or clr.
- clr and load same cycle with load_val=500: count=0 (clr wins). Next cycle, load_val=1500 with MAX_VAL=1023: count=1023; cnt_stb pulses both cycles.
- en dropped at prescaler=2 (PRESCALE=4) then reasserted: next tick arrives 4 RUN cycles after re-entry; count unchanged while IDLE.
- SATURATE_EN defined, up, continuous, count=1022: ticks give 1023, 1023, 1023; tc on each terminal tick; cnt_stb only on the 1022->1023 step.
